// File: rtl/alu_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_pkg
// Description : Shared MIPS opcode/funct/ALU-code constants and remap entry type
// Revision    : 1.0  initial release
// ============================================================================
package alu_decode_pkg;

    // Entry fields are stored wide enough for any supported opcode/ALU width
    localparam int REMAP_FIELD_W = 16;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    localparam logic [5:0] ALU_ADD   = 6'h20;
    localparam logic [5:0] ALU_SUB   = 6'h22;
    localparam logic [5:0] ALU_SLT   = 6'h2A;

    typedef struct packed {
        logic                     en;
        logic [REMAP_FIELD_W-1:0] opcode;
        logic [REMAP_FIELD_W-1:0] aluop;
        logic                     arith;
    } remap_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_default_map.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_default_map
// Description : Combinational fixed opcode -> ALU code map and arith-class flag
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_default_map
    import alu_decode_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [OPCODE_W-1:0] i_funct,
    output logic [ALUOP_W-1:0]  o_aluop,
    output logic                o_arith
);

    always_comb begin
        o_aluop = ALUOP_W'(i_opcode);
        if (i_opcode == OPCODE_W'(OP_BEQ) || i_opcode == OPCODE_W'(OP_BNE)) begin
            o_aluop = ALUOP_W'(ALU_SUB);
        end else if (i_opcode == OPCODE_W'(OP_REGIMM) || i_opcode == OPCODE_W'(OP_BLEZ) ||
                     i_opcode == OPCODE_W'(OP_BGTZ)) begin
            o_aluop = ALUOP_W'(ALU_SLT);
        end else if (i_opcode == OPCODE_W'(OP_LB) || i_opcode == OPCODE_W'(OP_LW) ||
                     i_opcode == OPCODE_W'(OP_SB) || i_opcode == OPCODE_W'(OP_SW) ||
                     i_opcode == OPCODE_W'(OP_JAL)) begin
            o_aluop = ALUOP_W'(ALU_ADD);
        end else if (i_opcode == OPCODE_W'(OP_RTYPE)) begin
            o_aluop = ALUOP_W'(i_funct);
        end
    end

    // R-type plus the immediate-arithmetic/logic group 0x08..0x0F
    assign o_arith = (i_opcode == OPCODE_W'(OP_RTYPE)) ||
                     ((i_opcode >= OPCODE_W'(8)) && (i_opcode <= OPCODE_W'(15)));

endmodule
`default_nettype wire

// File: rtl/alu_op_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode_stage
// Description : Registered decode stage: default map, override table, HI/LO interlock
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode_stage
    import alu_decode_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 6,
    parameter int REMAP_DEPTH = 4,
    parameter int MULDIV_LAT  = 4,
    localparam int IDX_W      = (REMAP_DEPTH > 1) ? $clog2(REMAP_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [OPCODE_W-1:0] in_funct,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic                out_arith,
    output logic                out_muldiv,
    output logic                out_remapped,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic                cfg_en,
    input  logic [OPCODE_W-1:0] cfg_opcode,
    input  logic [ALUOP_W-1:0]  cfg_aluop,
    input  logic                cfg_arith,
    output logic                hilo_busy
);

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);

    remap_entry_t               r_table [REMAP_DEPTH];
    logic [CNT_W-1:0]           r_hilo_cnt;
    logic                       r_out_valid;
    logic [ALUOP_W-1:0]         r_out_aluop;
    logic                       r_out_arith;
    logic                       r_out_muldiv;
    logic                       r_out_remapped;

    logic [ALUOP_W-1:0]         w_def_aluop;
    logic                       w_def_arith;
    logic                       w_hit;
    logic [ALUOP_W-1:0]         w_hit_aluop;
    logic                       w_hit_arith;
    logic                       w_rtype;
    logic                       w_muldiv;
    logic                       w_hilo_read;
    logic                       w_hazard;
    logic                       w_accept;

    alu_op_default_map #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_default_map (
        .i_opcode (in_opcode),
        .i_funct  (in_funct),
        .o_aluop  (w_def_aluop),
        .o_arith  (w_def_arith)
    );

    // Scan high to low so the lowest matching index is the one left standing
    always_comb begin
        w_hit       = 1'b0;
        w_hit_aluop = '0;
        w_hit_arith = 1'b0;
        for (int i = REMAP_DEPTH - 1; i >= 0; i--) begin
            if (r_table[i].en && (r_table[i].opcode[OPCODE_W-1:0] == in_opcode)) begin
                w_hit       = 1'b1;
                w_hit_aluop = r_table[i].aluop[ALUOP_W-1:0];
                w_hit_arith = r_table[i].arith;
            end
        end
    end

    assign w_rtype     = (in_opcode == OPCODE_W'(OP_RTYPE));
    assign w_muldiv    = w_rtype && ((in_funct == OPCODE_W'(FN_MULT)) || (in_funct == OPCODE_W'(FN_MULTU)) ||
                                     (in_funct == OPCODE_W'(FN_DIV))  || (in_funct == OPCODE_W'(FN_DIVU)));
    assign w_hilo_read = w_rtype && ((in_funct == OPCODE_W'(FN_MFHI)) || (in_funct == OPCODE_W'(FN_MFLO)));

    assign hilo_busy = (r_hilo_cnt != '0);
    assign w_hazard  = hilo_busy && (w_muldiv || w_hilo_read);
    assign in_ready  = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REMAP_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < REMAP_DEPTH)) begin
            r_table[cfg_idx].en     <= cfg_en;
            r_table[cfg_idx].opcode <= REMAP_FIELD_W'(cfg_opcode);
            r_table[cfg_idx].aluop  <= REMAP_FIELD_W'(cfg_aluop);
            r_table[cfg_idx].arith  <= cfg_arith;
        end
    end

    // Counter runs independently of output backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hilo_cnt <= '0;
        end else if (w_accept && w_muldiv) begin
            r_hilo_cnt <= CNT_W'(MULDIV_LAT);
        end else if (r_hilo_cnt != '0) begin
            r_hilo_cnt <= r_hilo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_aluop    <= '0;
            r_out_arith    <= 1'b0;
            r_out_muldiv   <= 1'b0;
            r_out_remapped <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_aluop    <= w_hit ? w_hit_aluop : w_def_aluop;
            r_out_arith    <= w_hit ? w_hit_arith : w_def_arith;
            r_out_muldiv   <= w_muldiv;
            r_out_remapped <= w_hit;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_aluop    = r_out_aluop;
    assign out_arith    = r_out_arith;
    assign out_muldiv   = r_out_muldiv;
    assign out_remapped = r_out_remapped;

endmodule
`default_nettype wire
